// File: rtl/expr_sched_pkg.sv
// Shared encodings for the expression scheduler: token kinds, operator codes,
// FSM states, token payload and operator precedence.
package expr_sched_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned KIND_W = 2;
  localparam int unsigned OP_W   = 2;

  typedef enum logic [KIND_W-1:0] {
    KIND_OPND = 2'b00,
    KIND_OPER = 2'b01,
    KIND_END  = 2'b10,
    KIND_ILL  = 2'b11
  } tok_kind_e;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ACCEPT   = 4'd1,
    S_CMP      = 4'd2,
    S_RED_REQ  = 4'd3,
    S_RED_WAIT = 4'd4,
    S_DRAIN    = 4'd5,
    S_POP_RES  = 4'd6,
    S_DONE     = 4'd7,
    S_ERR      = 4'd8
  } state_e;

  typedef struct packed {
    logic [KIND_W-1:0] kind;
    logic [DATA_W-1:0] data;
  } tok_t;

  // mul/div bind tighter than add/sub; the code's MSB is the precedence level
  function automatic logic prec(input logic [OP_W-1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/sched_timer.sv
// Wait-cycle counter for an outstanding reduction; expired flags the last
// permitted waiting cycle.
module sched_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;
  localparam int unsigned LAST  = (LIMIT > 0) ? LIMIT - 1 : 0;

  logic [CNT_W-1:0] count;

  // counter saturates at LAST so it never wraps while the FSM is leaving
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = enable && (count == CNT_W'(LAST));

endmodule

// File: rtl/expr_sched.sv
// Shunting-yard scheduler: accepts infix tokens, drives external operand and
// operator stacks, and hands each reduction to an external calculation unit.
module expr_sched
  import expr_sched_pkg::*;
#(
  parameter int unsigned CALC_TIMEOUT = 255,
  parameter int unsigned OPND_DEPTH   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tok_valid,
  output logic              tok_ready,
  input  logic [KIND_W-1:0] tok_kind,
  input  logic [DATA_W-1:0] tok_data,
  output logic [DATA_W-1:0] opndSTK_Din,
  output logic              opndSTK_push,
  output logic              opndSTK_pop,
  input  logic [DATA_W-1:0] opndSTK_Dout,
  input  logic              opndSTK_full,
  output logic [OP_W-1:0]   opSTK_Din,
  output logic              opSTK_push,
  output logic              opSTK_pop,
  input  logic [OP_W-1:0]   opSTK_Dout,
  input  logic              opSTK_empty,
  input  logic              opSTK_full,
  output logic              calc_start,
  input  logic              calc_complete,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              error
);

  localparam int unsigned DEPTH_W = $clog2(OPND_DEPTH + 1);

  state_e             state;
  state_e             next_state;
  logic [DEPTH_W-1:0] depth;
  logic [OP_W-1:0]    pend_op;
  logic               expect_opnd;
  logic               from_end;

  tok_t tok;
  logic opnd_ok;
  logic oper_ok;
  logic end_ok;
  logic reduce;
  logic depth_ge2;
  logic depth_eq1;
  logic timer_clear;
  logic timer_en;
  logic timer_expired;

  assign tok = '{kind: tok_kind, data: tok_data};

  // token legality; anything that is not one of these three sends us to ERR
  assign opnd_ok = (tok.kind == KIND_OPND) && expect_opnd && !opndSTK_full &&
                   (depth != DEPTH_W'(OPND_DEPTH));
  assign oper_ok = (tok.kind == KIND_OPER) && !expect_opnd;
  assign end_ok  = (tok.kind == KIND_END)  && !expect_opnd;

  // left-associative: equal precedence on the stack reduces first
  assign reduce    = !opSTK_empty && (prec(opSTK_Dout) >= prec(pend_op));
  assign depth_ge2 = depth >= DEPTH_W'(2);
  assign depth_eq1 = depth == DEPTH_W'(1);

  assign timer_clear = (state == S_RED_REQ);
  assign timer_en    = (state == S_RED_WAIT);

  sched_timer #(
    .LIMIT(CALC_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(timer_expired)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: next_state = S_ACCEPT;
      S_ACCEPT: begin
        if (tok_valid) begin
          if (opnd_ok)      next_state = S_ACCEPT;
          else if (oper_ok) next_state = S_CMP;
          else if (end_ok)  next_state = S_DRAIN;
          else              next_state = S_ERR;
        end
      end
      S_CMP: begin
        if (reduce)          next_state = S_RED_REQ;
        else if (opSTK_full) next_state = S_ERR;
        else                 next_state = S_ACCEPT;
      end
      S_RED_REQ: next_state = depth_ge2 ? S_RED_WAIT : S_ERR;
      S_RED_WAIT: begin
        if (calc_complete)      next_state = from_end ? S_DRAIN : S_CMP;
        else if (timer_expired) next_state = S_ERR;
      end
      S_DRAIN:   next_state = opSTK_empty ? S_POP_RES : S_RED_REQ;
      S_POP_RES: next_state = depth_eq1 ? S_DONE : S_ERR;
      S_DONE:    next_state = S_ACCEPT;
      S_ERR:     next_state = S_ERR;
      default:   next_state = S_ERR;
    endcase
  end

  // output decode; stack strobes stay low outside their owning states
  always_comb begin
    tok_ready    = 1'b0;
    opndSTK_Din  = '0;
    opndSTK_push = 1'b0;
    opndSTK_pop  = 1'b0;
    opSTK_Din    = '0;
    opSTK_push   = 1'b0;
    opSTK_pop    = 1'b0;
    calc_start   = 1'b0;
    result_valid = 1'b0;
    error        = 1'b0;
    case (state)
      S_ACCEPT: begin
        tok_ready    = 1'b1;
        opndSTK_Din  = tok.data;
        opndSTK_push = tok_valid && opnd_ok;
      end
      S_CMP: begin
        opSTK_Din  = pend_op;
        opSTK_push = !reduce && !opSTK_full;
      end
      S_RED_REQ: calc_start   = depth_ge2;
      S_POP_RES: opndSTK_pop  = depth_eq1;
      S_DONE:    result_valid = 1'b1;
      S_ERR:     error        = 1'b1;
      default: ;
    endcase
  end

  // scheduler bookkeeping: operand depth, pending operator, syntax flag, result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth       <= '0;
      pend_op     <= '0;
      expect_opnd <= 1'b1;
      from_end    <= 1'b0;
      result      <= '0;
    end else begin
      case (state)
        S_ACCEPT: begin
          if (tok_valid) begin
            if (opnd_ok) begin
              depth       <= depth + DEPTH_W'(1);
              expect_opnd <= 1'b0;
            end else if (oper_ok) begin
              pend_op     <= tok.data[OP_W-1:0];
              expect_opnd <= 1'b1;
              from_end    <= 1'b0;
            end else if (end_ok) begin
              from_end <= 1'b1;
            end
          end
        end
        S_RED_WAIT: begin
          if (calc_complete) depth <= depth - DEPTH_W'(1);
        end
        S_POP_RES: begin
          if (depth_eq1) begin
            result <= opndSTK_Dout;
            depth  <= '0;
          end
        end
        S_DONE: expect_opnd <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_expr_sched.sv
// Directed bench for expr_sched with behavioural operand/operator stacks and
// a calculation unit that can be told to withhold completion.
module tb_expr_sched;

  localparam int OPND_CAP = 16;
  localparam int OP_CAP   = 8;
  localparam int CALC_LAT = 3;

  localparam logic [8:0] O_ADD = 9'h100;
  localparam logic [8:0] O_SUB = 9'h101;
  localparam logic [8:0] O_MUL = 9'h102;
  localparam logic [8:0] O_DIV = 9'h103;
  localparam logic [8:0] Z     = 9'h000;

  localparam logic [1:0] K_OPND = 2'b00;
  localparam logic [1:0] K_OPER = 2'b01;
  localparam logic [1:0] K_END  = 2'b10;
  localparam logic [1:0] K_ILL  = 2'b11;

  typedef struct packed {
    logic [3:0]       n;
    logic [0:9][8:0]  tok;
    logic [7:0]       exp_res;
    logic [3:0]       exp_starts;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tok_valid;
  logic       tok_ready;
  logic [1:0] tok_kind;
  logic [7:0] tok_data;
  logic [7:0] opndSTK_Din;
  logic       opndSTK_push;
  logic       opndSTK_pop;
  logic [7:0] opndSTK_Dout;
  logic       opndSTK_full;
  logic [1:0] opSTK_Din;
  logic       opSTK_push;
  logic       opSTK_pop;
  logic [1:0] opSTK_Dout;
  logic       opSTK_empty;
  logic       opSTK_full;
  logic       calc_start;
  logic       calc_complete;
  logic [7:0] result;
  logic       result_valid;
  logic       error;

  logic [7:0] opnd_mem [OPND_CAP];
  logic [1:0] op_mem   [OP_CAP];
  int         opnd_sp;
  int         op_sp;
  int         calc_cnt;
  logic       calc_hold;

  int n_start     = 0;
  int n_opnd_push = 0;
  int n_op_push   = 0;
  int n_conflict  = 0;
  int n_tests     = 0;
  int n_fail      = 0;

  vec_t vecs [8];

  expr_sched #(
    .CALC_TIMEOUT(255),
    .OPND_DEPTH  (16)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .tok_valid    (tok_valid),
    .tok_ready    (tok_ready),
    .tok_kind     (tok_kind),
    .tok_data     (tok_data),
    .opndSTK_Din  (opndSTK_Din),
    .opndSTK_push (opndSTK_push),
    .opndSTK_pop  (opndSTK_pop),
    .opndSTK_Dout (opndSTK_Dout),
    .opndSTK_full (opndSTK_full),
    .opSTK_Din    (opSTK_Din),
    .opSTK_push   (opSTK_push),
    .opSTK_pop    (opSTK_pop),
    .opSTK_Dout   (opSTK_Dout),
    .opSTK_empty  (opSTK_empty),
    .opSTK_full   (opSTK_full),
    .calc_start   (calc_start),
    .calc_complete(calc_complete),
    .result       (result),
    .result_valid (result_valid),
    .error        (error)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] calc_op(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] op);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a * b;
      default: return (b == 8'd0) ? 8'hFF : a / b;
    endcase
  endfunction

  assign opndSTK_Dout = (opnd_sp > 0) ? opnd_mem[opnd_sp-1] : 8'h00;
  assign opndSTK_full = (opnd_sp >= OPND_CAP);
  assign opSTK_Dout   = (op_sp > 0) ? op_mem[op_sp-1] : 2'b00;
  assign opSTK_empty  = (op_sp == 0);
  assign opSTK_full   = (op_sp >= OP_CAP);

  // stack owners plus calculation unit: pop b, a, op; push a op b
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd_sp       <= 0;
      op_sp         <= 0;
      calc_cnt      <= 0;
      calc_complete <= 1'b0;
    end else begin
      calc_complete <= 1'b0;
      if (opndSTK_push && opnd_sp < OPND_CAP) begin
        opnd_mem[opnd_sp] <= opndSTK_Din;
        opnd_sp           <= opnd_sp + 1;
      end
      if (opndSTK_pop && opnd_sp > 0) opnd_sp <= opnd_sp - 1;
      if (opSTK_push && op_sp < OP_CAP) begin
        op_mem[op_sp] <= opSTK_Din;
        op_sp         <= op_sp + 1;
      end
      if (calc_start) begin
        calc_cnt <= CALC_LAT;
      end else if (calc_cnt == 1 && !calc_hold) begin
        if (opnd_sp >= 2 && op_sp >= 1) begin
          opnd_mem[opnd_sp-2] <= calc_op(opnd_mem[opnd_sp-2], opnd_mem[opnd_sp-1],
                                         op_mem[op_sp-1]);
          opnd_sp <= opnd_sp - 1;
          op_sp   <= op_sp - 1;
        end
        calc_cnt      <= 0;
        calc_complete <= 1'b1;
      end else if (calc_cnt > 1) begin
        calc_cnt <= calc_cnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (calc_start)   n_start     <= n_start + 1;
      if (opndSTK_push) n_opnd_push <= n_opnd_push + 1;
      if (opSTK_push)   n_op_push   <= n_op_push + 1;
      if ((opndSTK_push && opndSTK_pop) || (opSTK_push && opSTK_pop))
        n_conflict <= n_conflict + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    tok_valid = 1'b0;
    calc_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // offer one token from a negedge, return at the negedge after it transfers
  task automatic send_tok(input logic [1:0] k, input logic [7:0] d);
    int b;
    b         = 0;
    tok_kind  = k;
    tok_data  = d;
    tok_valid = 1'b1;
    while (!tok_ready && b < 600) begin
      @(negedge clk);
      b++;
    end
    if (!tok_ready) begin
      check("tok_ready_wait", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    tok_valid = 1'b0;
  endtask

  task automatic send_enc(input logic [8:0] t);
    if (t[8]) send_tok(K_OPER, {6'b0, t[1:0]});
    else      send_tok(K_OPND, t[7:0]);
  endtask

  task automatic wait_done(output logic seen);
    int b;
    b = 0;
    while (!result_valid && b < 300) begin
      @(negedge clk);
      b++;
    end
    seen = result_valid;
  endtask

  task automatic wait_start(input int s);
    int b;
    b = 0;
    while (n_start == s && b < 100) begin
      @(negedge clk);
      b++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    int   s;
    int   p;
    int   q;
    int   cyc;
    int   bad;
    vec_t v;

    vecs[0] = '{n: 4'd3, tok: {9'd3, O_ADD, 9'd4, {7{Z}}}, exp_res: 8'd7, exp_starts: 4'd1};
    vecs[1] = '{n: 4'd5, tok: {9'd2, O_ADD, 9'd3, O_MUL, 9'd4, {5{Z}}}, exp_res: 8'd14, exp_starts: 4'd2};
    vecs[2] = '{n: 4'd5, tok: {9'd8, O_SUB, 9'd3, O_SUB, 9'd2, {5{Z}}}, exp_res: 8'd3, exp_starts: 4'd2};
    vecs[3] = '{n: 4'd1, tok: {9'd7, {9{Z}}}, exp_res: 8'd7, exp_starts: 4'd0};
    vecs[4] = '{n: 4'd5, tok: {9'd100, O_DIV, 9'd7, O_MUL, 9'd3, {5{Z}}}, exp_res: 8'd42, exp_starts: 4'd2};
    vecs[5] = '{n: 4'd3, tok: {9'd20, O_MUL, 9'd20, {7{Z}}}, exp_res: 8'd144, exp_starts: 4'd1};
    vecs[6] = '{n: 4'd7, tok: {9'd9, O_SUB, 9'd2, O_MUL, 9'd3, O_ADD, 9'd1, {3{Z}}}, exp_res: 8'd4, exp_starts: 4'd3};
    vecs[7] = '{n: 4'd3, tok: {9'd5, O_SUB, 9'd9, {7{Z}}}, exp_res: 8'd252, exp_starts: 4'd1};

    rst_n     = 1'b0;
    tok_valid = 1'b0;
    tok_kind  = 2'b00;
    tok_data  = 8'h00;
    calc_hold = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outputs", {tok_ready, error, result_valid, calc_start, opndSTK_push,
                          opndSTK_pop, opSTK_push, opSTK_pop}, 32'd0);
    check("rst_result", result, 32'd0);
    rst_n = 1'b1;
    check("idle_not_ready", tok_ready, 32'd0);
    @(negedge clk);
    check("ready_after_release", tok_ready, 32'd1);

    // back-to-back well-formed expressions
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      s = n_start;
      for (int j = 0; j < int'(v.n); j++) send_enc(v.tok[j]);
      send_tok(K_END, 8'h00);
      wait_done(seen);
      check($sformatf("v%0d_done", i), seen, 32'd1);
      if (seen) begin
        check($sformatf("v%0d_result", i), result, v.exp_res);
        check($sformatf("v%0d_starts", i), n_start - s, v.exp_starts);
        check($sformatf("v%0d_error", i), error, 32'd0);
        @(negedge clk);
        check($sformatf("v%0d_valid_pulse", i), result_valid, 32'd0);
        check($sformatf("v%0d_result_held", i), result, v.exp_res);
      end
    end

    // '*' stacks above '+' without reducing
    do_reset();
    s = n_start;
    send_enc(9'd2); send_enc(O_ADD); send_enc(9'd3); send_enc(O_MUL);
    @(negedge clk);
    check("prec_op_depth", op_sp, 32'd2);
    check("prec_op_top", op_mem[1], 32'd2);
    check("prec_op_bottom", op_mem[0], 32'd0);
    check("prec_no_reduce", n_start - s, 32'd0);
    send_enc(9'd4);
    send_tok(K_END, 8'h00);
    wait_done(seen);
    check("prec_result", result, 32'd14);
    check("prec_starts", n_start - s, 32'd2);

    // equal precedence reduces on arrival of the second '-'
    s = n_start;
    send_enc(9'd8); send_enc(O_SUB); send_enc(9'd3);
    check("assoc_before", n_start - s, 32'd0);
    send_enc(O_SUB);
    repeat (10) @(negedge clk);
    check("assoc_reduce_on_op", n_start - s, 32'd1);
    check("assoc_op_depth", op_sp, 32'd1);
    send_enc(9'd2);
    send_tok(K_END, 8'h00);
    wait_done(seen);
    check("assoc_result", result, 32'd3);
    check("assoc_starts", n_start - s, 32'd2);

    // calculation unit never completes
    do_reset();
    calc_hold = 1'b1;
    s = n_start;
    send_enc(9'd3); send_enc(O_ADD); send_enc(9'd4);
    send_tok(K_END, 8'h00);
    wait_start(s);
    check("to_start_seen", n_start - s, 32'd1);
    cyc = 0;
    bad = 0;
    while (!error && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (!error && (tok_ready || opndSTK_push || opndSTK_pop || opSTK_push ||
                     opSTK_pop || calc_start)) bad++;
    end
    check("timeout_cycles", cyc, 32'd255);
    check("wait_strobes_quiet", bad, 32'd0);
    check("timeout_ready_low", tok_ready, 32'd0);
    calc_hold = 1'b0;
    tok_valid = 1'b1;
    tok_kind  = K_OPND;
    repeat (10) @(negedge clk);
    check("err_sticky", error, 32'd1);
    check("err_ready_low", tok_ready, 32'd0);
    tok_valid = 1'b0;

    // syntax and illegal-token errors
    do_reset();
    p = n_opnd_push; q = n_op_push;
    send_enc(O_ADD);
    check("e_lead_op_err", error, 32'd1);
    check("e_lead_op_push", (n_opnd_push - p) + (n_op_push - q), 32'd0);

    do_reset();
    p = n_opnd_push;
    send_enc(9'd5);
    check("e_two_opnd_pre", error, 32'd0);
    send_enc(9'd7);
    check("e_two_opnd_err", error, 32'd1);
    check("e_two_opnd_push", n_opnd_push - p, 32'd1);

    do_reset();
    p = n_opnd_push; q = n_op_push;
    send_tok(K_ILL, 8'd9);
    check("e_illegal_err", error, 32'd1);
    check("e_illegal_push", (n_opnd_push - p) + (n_op_push - q), 32'd0);

    do_reset();
    q = n_op_push;
    send_enc(9'd1); send_enc(O_ADD);
    send_tok(K_END, 8'h00);
    check("e_end_after_op_err", error, 32'd1);
    check("e_end_after_op_push", n_op_push - q, 32'd1);

    // reset while a reduction is outstanding
    do_reset();
    calc_hold = 1'b1;
    s = n_start;
    send_enc(9'd3); send_enc(O_ADD); send_enc(9'd4);
    send_tok(K_END, 8'h00);
    wait_start(s);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outputs", {tok_ready, error, result_valid, calc_start, opndSTK_push,
                             opndSTK_pop, opSTK_push, opSTK_pop}, 32'd0);
    check("midrst_result", result, 32'd0);
    calc_hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_idle", tok_ready, 32'd0);
    @(negedge clk);
    check("midrst_accept", tok_ready, 32'd1);
    s = n_start;
    send_enc(9'd1); send_enc(O_ADD); send_enc(9'd1);
    send_tok(K_END, 8'h00);
    wait_done(seen);
    check("midrst_done", seen, 32'd1);
    check("midrst_fresh_result", result, 32'd2);
    check("midrst_fresh_starts", n_start - s, 32'd1);
    check("midrst_fresh_error", error, 32'd0);

    check("stack_push_pop_overlap", n_conflict, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/expr_sched.md
EXPR_SCHED -- requirements
Module: expr_sched

Interface
REQ-001 SHALL have parameter CALC_TIMEOUT, default 255: max cycles waiting for calc_complete before error.
REQ-002 SHALL have parameter OPND_DEPTH, default 16: operand stack capacity, sizes the internal depth counter.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 tok_valid  in  1 / tok_ready  out  1: token handshake; a token transfers on a cycle with both high.
REQ-006 tok_kind  in  2: 00 operand, 01 operator, 10 end, 11 illegal.
REQ-007 tok_data  in  8: operand value, or operator code in bits [1:0] (00 add, 01 sub, 10 mul, 11 div).
REQ-008 opndSTK_Din  out  8, opndSTK_push  out  1, opndSTK_pop  out  1, opndSTK_Dout  in  8 (top, peek), opndSTK_full  in  1.
REQ-009 opSTK_Din  out  2, opSTK_push  out  1, opSTK_pop  out  1, opSTK_Dout  in  2 (top, peek), opSTK_empty  in  1, opSTK_full  in  1.
REQ-010 calc_start  out  1 / calc_complete  in  1: one reduction handed to the calculation unit.
REQ-011 result  out  8, result_valid  out  1, error  out  1.

Function
REQ-012 SHALL implement shunting-yard scheduling, FSM states IDLE, ACCEPT, CMP, RED_REQ, RED_WAIT, DRAIN, POP_RES, DONE, ERR.
REQ-013 tok_ready SHALL be high only in ACCEPT; IDLE goes to ACCEPT one cycle after reset release.
REQ-014 Operand token in ACCEPT: opndSTK_push=1, opndSTK_Din=tok_data in the same cycle; depth counter +1; stay ACCEPT.
REQ-015 Operator token: latch code to pend_op, go to CMP.
REQ-016 Precedence = op[1] (mul/div high); left-associative.
REQ-017 CMP: if !opSTK_empty and prec(opSTK_Dout) >= prec(pend_op) go RED_REQ; else opSTK_push=1 with opSTK_Din=pend_op for one cycle, return ACCEPT.
REQ-018 RED_REQ: requires depth >= 2, else ERR; asserts calc_start for exactly one cycle; go RED_WAIT.
REQ-019 RED_WAIT: all four stack strobes SHALL be 0 (calc unit owns stacks); on calc_complete depth -1, go back to CMP (operator path) or DRAIN (end path).
REQ-020 Timeout counter clears on entering RED_WAIT; reaching CALC_TIMEOUT without calc_complete -> ERR.
REQ-021 End token: go DRAIN; DRAIN with !opSTK_empty -> RED_REQ; with opSTK_empty -> POP_RES.
REQ-022 POP_RES: depth must equal 1, else ERR; capture result <= opndSTK_Dout, opndSTK_pop=1 one cycle, depth -> 0; go DONE.
REQ-023 DONE: result_valid=1 for exactly one cycle, result held until next DONE; then ACCEPT.
REQ-024 Syntax check: expect_opnd flag set after reset/DONE/operator, cleared after operand; operator or end while expect_opnd, or operand while !expect_opnd -> ERR.
REQ-025 Operand token with opndSTK_full or depth = OPND_DEPTH, operator push with opSTK_full, or tok_kind 11 -> ERR, no push issued.
REQ-026 ERR: error=1 sticky, tok_ready=0, all strobes 0; exit only by reset.
REQ-027 push and pop on the same stack SHALL never assert in the same cycle.

Reset
REQ-028 reset low SHALL immediately force IDLE, all strobes/calc_start/tok_ready/result_valid/error 0, result 0, depth 0, timeout 0, expect_opnd 1, pend_op 00.
REQ-029 Reset mid-reduction SHALL abandon it; stacks are reset by their owners on the same reset.

Structure
REQ-030 Shared package SHALL hold token-kind and operator encodings, state encoding, and the prec function.
REQ-031 Timeout counter SHALL be a separate sub-module, sched_timer (clear, enable, expired).

Verification
REQ-032 Tokens 3,+,4,end -> one calc_start, result_valid with result taken from stack top, error 0.
REQ-033 Tokens 2,+,3,*,4,end -> '*' pushed above '+' (no reduction on '*'), two calc_start pulses only after end.
REQ-034 Tokens 8,-,3,-,2,end -> reduction issued when second '-' arrives (equal precedence), then one more at end.
REQ-035 calc_complete withheld 255 cycles -> error=1 at timeout, tok_ready stays 0.
REQ-036 Tokens +,... or 5,7 -> error=1 on offending token, no stack strobe.
REQ-037 reset low during RED_WAIT -> all outputs 0 immediately, ACCEPT reached after release, fresh 1,+,1,end completes normally.
